// File: rtl/chaotic_z_bitstream.sv
// chaotic_z_bitstream: turns float64 z(n+1) samples into a serial chaotic bit stream.
// A fixed mantissa field of each finite, non-zero sample is taken and inverted
// for negative z. It goes through a one-cycle capture stage and a small FIFO,
// then leaves MSB-first on a ready/valid one-bit stream.
module chaotic_z_bitstream #(
    parameter int DATA_WIDTH      = 64,
    parameter int BITS_PER_SAMPLE = 8,
    parameter int MANT_LSB        = 20,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  zn1_valid,
    input  logic [DATA_WIDTH-1:0] zn1,
    output logic                  bit_valid,
    input  logic                  bit_ready,
    output logic                  bit_out,
    output logic                  overflow,
    output logic                  bad_sample,
    output logic [15:0]           sample_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(BITS_PER_SAMPLE + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // classification and field extraction (combinational on the input word)
    logic [10:0]                exponent;
    logic                       sample_ok;
    logic [BITS_PER_SAMPLE-1:0] field_next;
    logic                       zn1_unused_parity;

    assign exponent  = zn1[62:52];
    assign sample_ok = (exponent != 11'h000) && (exponent != 11'h7FF);
    // Mantissa bits outside the field carry no meaning here; fold them away.
    assign zn1_unused_parity = ^zn1;

    generate
        for (genvar gi = 0; gi < BITS_PER_SAMPLE; gi++) begin : g_field
            assign field_next[gi] = zn1[MANT_LSB + gi] ^ zn1[63];
        end
    endgenerate

    // capture stage
    logic                       cap_valid_reg;
    logic [BITS_PER_SAMPLE-1:0] cap_data_reg;
    logic                       bad_sample_reg;

    // Register accepted samples for one cycle and latch the reject flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_reg  <= 1'b0;
            cap_data_reg   <= '0;
            bad_sample_reg <= 1'b0;
        end else begin
            cap_valid_reg <= zn1_valid && sample_ok;
            if (zn1_valid && sample_ok)
                cap_data_reg <= field_next;
            if (zn1_valid && !sample_ok)
                bad_sample_reg <= 1'b1;
        end
    end

    // sample FIFO
    logic [BITS_PER_SAMPLE-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]           count_reg;
    logic [15:0]                sample_cnt_reg;
    logic                       overflow_reg;
    logic                       fifo_full, fifo_empty, pop, wr_en, drop;

    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    // A full FIFO still accepts a write when the serializer pops in the same cycle.
    assign wr_en      = cap_valid_reg && (!fifo_full || pop);
    assign drop       = cap_valid_reg && fifo_full && !pop;

    // FIFO storage write port; the read side is registered by the shift register.
    always_ff @(posedge clk) begin
        if (wr_en)
            fifo_mem[wr_ptr_reg] <= cap_data_reg;
    end

    // FIFO pointers, occupancy, sample counter and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            sample_cnt_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg     <= wr_ptr_reg + 1'b1;
                sample_cnt_reg <= sample_cnt_reg + 16'd1;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop)
                overflow_reg <= 1'b1;
        end
    end

    // serializer
    state_t                     state_reg, state_next;
    logic [BITS_PER_SAMPLE-1:0] shift_reg;
    logic [BC_W-1:0]            bit_cnt_reg;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next state and pop decision; a reload on the last bit avoids any bubble.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_ready && (bit_cnt_reg == '0)) begin
                    if (!fifo_empty)
                        pop = 1'b1;
                    else
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register and bit counter: load on pop, shift on an accepted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (pop) begin
            shift_reg   <= fifo_mem[rd_ptr_reg];
            bit_cnt_reg <= BC_W'(BITS_PER_SAMPLE - 1);
        end else if ((state_reg == SHIFT) && bit_ready && (bit_cnt_reg != '0)) begin
            shift_reg   <= shift_reg << 1;
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
        end
    end

    // Stream outputs follow registered state only, so they hold steady during a stall.
    always_comb begin
        bit_valid = (state_reg == SHIFT);
        bit_out   = (state_reg == SHIFT) && shift_reg[BITS_PER_SAMPLE-1];
    end

    assign overflow   = overflow_reg;
    assign bad_sample = bad_sample_reg;
    assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_chaotic_z_bitstream.sv
// Testbench for chaotic_z_bitstream: directed samples with hand-computed fields.
// Expected serial bits are queued at stimulus time and a negedge monitor checks them.
module tb_chaotic_z_bitstream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        zn1_valid = 1'b0;
    logic [63:0] zn1 = 64'h0;
    logic        bit_ready = 1'b0;
    logic        bit_valid, bit_out, overflow, bad_sample;
    logic [15:0] sample_cnt;

    int checks = 0;
    int failures = 0;
    bit exp_q[$];
    bit rand_ready = 1'b0;
    bit stall_prev = 1'b0;
    bit prev_bit = 1'b0;

    logic [63:0] ovf_vec [6] = '{64'h3FF0_0000_0010_0000, 64'h3FF0_0000_0800_0000,
                                 64'h3FF0_0000_03C0_0000, 64'h3FF0_0000_0C30_0000,
                                 64'h3FF0_0000_0960_0000, 64'h3FF0_0000_0770_0000};
    logic [7:0]  ovf_field [6] = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h96, 8'h77};
    logic [63:0] rnd_vec [3] = '{64'hC000_0000_0DE0_0000, 64'h4010_0000_0B70_0000,
                                 64'h3FE0_0000_0610_0000};
    logic [7:0]  rnd_field [3] = '{8'h21, 8'hB7, 8'h61};

    chaotic_z_bitstream #(
        .DATA_WIDTH(64), .BITS_PER_SAMPLE(8), .MANT_LSB(20), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .zn1_valid(zn1_valid), .zn1(zn1),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_out(bit_out),
        .overflow(overflow), .bad_sample(bad_sample), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endfunction

    function automatic void check_cnt(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    function automatic void push_field(input logic [7:0] f);
        for (int i = 7; i >= 0; i--)
            exp_q.push_back(f[i]);
    endfunction

    // Monitor: compare every accepted bit with the scoreboard and check stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_bit("stall_valid_hold", bit_valid, 1'b1);
                check_bit("stall_bit_hold", bit_out, prev_bit);
            end
            if (bit_valid && bit_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bit actual=%0b required=none", bit_out);
                end else begin
                    check_bit("serial_bit", bit_out, exp_q.pop_front());
                end
            end
            stall_prev = bit_valid && !bit_ready;
            prev_bit   = bit_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready)
            bit_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [63:0] v);
        zn1       = v;
        zn1_valid = 1'b1;
        step();
        zn1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check_bit("drain_done", exp_q.size() == 0, 1'b1);
    endtask

    initial begin
        int run;
        int n;

        // reset state
        repeat (3) step();
        @(negedge clk);
        check_bit("rst_bit_valid", bit_valid, 1'b0);
        check_bit("rst_bit_out", bit_out, 1'b0);
        check_bit("rst_overflow", overflow, 1'b0);
        check_bit("rst_bad_sample", bad_sample, 1'b0);
        check_cnt("rst_sample_cnt", sample_cnt, 16'd0);
        step();
        rst_n = 1'b1;

        // basic extraction with latency
        bit_ready = 1'b1;
        push_field(8'hFF);
        send(64'h3FF0_0000_0FF0_0000);
        @(negedge clk); check_bit("lat_t1_valid", bit_valid, 1'b0);
        @(negedge clk); check_bit("lat_t2_valid", bit_valid, 1'b0);
        check_cnt("lat_t2_cnt", sample_cnt, 16'd1);
        @(negedge clk); check_bit("lat_t3_valid", bit_valid, 1'b1);
        drain(50);
        @(negedge clk); check_bit("basic_valid_falls", bit_valid, 1'b0);
        step();

        // sign inversion
        push_field(8'h5A);
        send(64'hBFF0_0000_0A50_0000);
        drain(50);
        check_cnt("sign_cnt", sample_cnt, 16'd2);

        // reject NaN, zero, denormal
        do_reset();
        send(64'h7FF8_0000_0000_0000);
        @(negedge clk); check_bit("bad_t1", bad_sample, 1'b1);
        step();
        send(64'h0000_0000_0000_0000);
        send(64'h0000_0000_0FF0_0000);
        repeat (10) step();
        @(negedge clk);
        check_bit("rej_no_valid", bit_valid, 1'b0);
        check_cnt("rej_cnt", sample_cnt, 16'd0);
        check_bit("rej_bad_sticky", bad_sample, 1'b1);
        check_bit("rej_no_overflow", overflow, 1'b0);
        step();

        // backpressure and overflow
        do_reset();
        bit_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5)
                push_field(ovf_field[i]);
            send(ovf_vec[i]);
            if (i == 5) begin
                @(negedge clk); check_bit("ovf_t1", overflow, 1'b0);
                @(negedge clk); check_bit("ovf_t2", overflow, 1'b1);
                step();
            end else begin
                repeat (4) step();
            end
        end
        check_cnt("ovf_cnt", sample_cnt, 16'd5);
        repeat (3) step();
        bit_ready = 1'b1;
        run = 0;
        repeat (40) begin
            @(negedge clk);
            if (bit_valid) run++;
        end
        check_cnt("gapless_bits", 16'(run), 16'd40);
        @(negedge clk); check_bit("ovf_end_idle", bit_valid, 1'b0);
        check_bit("ovf_queue_empty", exp_q.size() == 0, 1'b1);
        step();

        // random stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_field(rnd_field[i]);
            send(rnd_vec[i]);
            repeat (15) step();
        end
        drain(600);
        rand_ready = 1'b0;
        bit_ready  = 1'b1;
        check_cnt("rand_cnt", sample_cnt, 16'd8);

        // reset in the middle of a sample, with a second sample waiting in the FIFO
        push_field(8'hC5);
        send(64'h3FF0_0000_0C50_0000);
        step();
        send(64'h3FF0_0000_0330_0000);
        n = 0;
        @(negedge clk);
        while (!bit_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_bit("mid_started", bit_valid, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_bit("mid_rst_valid", bit_valid, 1'b0);
        check_bit("mid_rst_bit_out", bit_out, 1'b0);
        check_bit("mid_rst_overflow", overflow, 1'b0);
        check_cnt("mid_rst_cnt", sample_cnt, 16'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        @(negedge clk); check_bit("mid_fifo_flushed", bit_valid, 1'b0);
        step();
        push_field(8'h81);
        send(64'h3FF0_0000_0810_0000);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); check_bit("post_rst_valid", bit_valid, 1'b1);
        drain(50);
        check_cnt("post_rst_cnt", sample_cnt, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/chaotic_z_bitstream.md
# chaotic_z_bitstream

Downstream consumer of the z-channel chaotic iteration stage. Takes each float64 `zn1` sample (`zn1_valid` strobe, one per iteration period), extracts a BITS_PER_SAMPLE-bit field from its mantissa, and buffers it in a small FIFO. It then serialises the field MSB-first onto a ready/valid single-bit stream that feeds the sequence output path. It also rejects non-finite and zero samples and flags buffer loss.

## Interface
- DATA_WIDTH, 64, width of `zn1`; fixed to IEEE-754 binary64 layout (sign 63, exponent 62:52, mantissa 51:0).
- BITS_PER_SAMPLE, 8, bits extracted per sample; legal range 1..32.
- MANT_LSB, 20, LSB position of the extracted field inside the mantissa; MANT_LSB+BITS_PER_SAMPLE-1 ≤ 51.
- FIFO_DEPTH, 4, sample FIFO entries; power of two, ≥ 2.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- zn1_valid  in  1  one-cycle strobe qualifying `zn1`.
- zn1  in  DATA_WIDTH  float64 z(n+1) from the z iteration stage.
- bit_valid  out  1  `bit_out` holds a valid bit.
- bit_ready  in  1  consumer accepts the bit when high together with `bit_valid`.
- bit_out  out  1  serial chaotic bit, MSB of each sample first.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- bad_sample  out  1  sticky: a sample was rejected because it was zero, denormal, Inf or NaN.
- sample_cnt  out  16  count of samples written to the FIFO; wraps at 65535→0.

## Operation
- **Classification** on `zn1_valid`: exponent == 0 or exponent == 11'h7FF → reject, set `bad_sample`, do not write.
- **Extraction** otherwise: sample = zn1[MANT_LSB +: BITS_PER_SAMPLE] XOR {BITS_PER_SAMPLE{zn1[63]}}, i.e. the field is inverted for negative z.
- **Capture**: an input stage register holds the sample and its write request for one cycle. The FIFO write happens the next cycle.
- **FIFO write**:
  - Count < FIFO_DEPTH → write and increment `sample_cnt`.
  - Count == FIFO_DEPTH with a pop in the same cycle → write succeeds.
  - Count == FIFO_DEPTH with no pop → drop the sample, set `overflow`; `sample_cnt` unchanged.
- **Serializer FSM**:
  - IDLE: `bit_valid`=0. If the FIFO is non-empty, pop into the shift register, load bit counter = BITS_PER_SAMPLE-1, go to SHIFT.
  - SHIFT: `bit_valid`=1, `bit_out` = shift register MSB. On handshake with counter > 0: shift left, decrement counter.
  - On handshake with counter == 0: if the FIFO is non-empty, pop and reload in the same cycle and stay in SHIFT (no bubble). Otherwise go to IDLE.
  - `bit_out` and `bit_valid` are stable while `bit_valid`=1 and `bit_ready`=0.
- Sticky flags clear only on reset.

## Timing
- Reset (async assert, release synchronised by design use): `bit_valid`=0, `bit_out`=0, `overflow`=0, `bad_sample`=0, `sample_cnt`=0, FIFO empty, FSM=IDLE, shift register 0.
- `zn1_valid` at cycle T, FIFO empty, FSM IDLE:
  - entry written at T+1 (`sample_cnt` increments, visible at T+2);
  - popped at T+2;
  - `bit_valid`=1 with the sample MSB at T+3.
- `bad_sample` rises at T+1 for a rejected sample. `overflow` rises at T+2 for a dropped sample.
- With `bit_ready` held high, one bit per cycle and back-to-back samples with no idle cycle.
- Reset asserted mid-sample discards the partial sample and all FIFO contents immediately.
- Upstream period is 244 cycles; the FIFO exists only to absorb `bit_ready` stalls.

## Test plan
- **Basic extraction**: zn1=64'h3FF0_0000_0FF0_0000 (MANT_LSB=20 → field 8'hFF), `bit_ready`=1 → `bit_valid` rises at T+3; `bit_out` = 1,1,1,1,1,1,1,1 over 8 cycles; `bit_valid` then falls; `sample_cnt`=1.
- **Sign inversion**: zn1=64'hBFF0_0000_0A50_0000 (field 8'hA5, sign 1) → serial bits 0,1,0,1,1,0,1,0 (8'h5A).
- **Reject**: zn1=64'h7FF8_0000_0000_0000 (NaN) then 64'h0 → no `bit_valid`, `bad_sample`=1, `sample_cnt`=0.
- **Backpressure/overflow**: `bit_ready`=0, 6 valid samples 5 cycles apart → 4 samples buffered plus the one loaded in the shift register; the 6th is dropped, `overflow`=1. Releasing `bit_ready` yields exactly 5×8 bits, in order, with no gaps.
- **Stall stability**: toggle `bit_ready` on a random pattern → each bit held unchanged until its handshake; output stream equals a reference model bit for bit.
- **Reset mid-stream**: assert `rst_n`=0 during bit 3 of a sample → all outputs 0 immediately. After release, the next valid sample is serialized from its MSB.
